// File: rtl/controller_pkg.sv
// Shared types and constants for the multicycle controller and its ALU decoder.
package controller_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_e;

    // True for the opcodes this controller knows how to sequence.
    function automatic logic is_legal_opcode(input logic [6:0] opc);
        logic legal;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JAL: legal = 1'b1;
            default:                      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from the instruction fields.
module alu_decoder
    import controller_pkg::*;
#(
    parameter int ALU_OP_W = 4
) (
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    output logic [ALU_OP_W-1:0] alu_control,
    output logic                alu_src_imm
);

    logic [3:0] op;

    // Register-register and immediate arithmetic share one funct3 map; only
    // the use of funct7_5 differs (no immediate subtract).
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt, input logic allow_sub);
        logic [3:0] r;
        case (f3)
            3'b000:  r = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    // Select the operation and operand-B source per opcode class.
    always_comb begin
        op          = ALU_ADD;
        alu_src_imm = 1'b0;
        case (opcode)
            OPC_OP:     op = arith_op(funct3, funct7_5, 1'b1);
            OPC_OP_IMM: begin
                op          = arith_op(funct3, funct7_5, 1'b0);
                alu_src_imm = 1'b1;
            end
            OPC_LOAD, OPC_STORE: begin
                op          = ALU_ADD;
                alu_src_imm = 1'b1;
            end
            OPC_LUI: begin
                op          = ALU_PASS_B;
                alu_src_imm = 1'b1;
            end
            OPC_BRANCH: begin
                case (funct3[2:1])
                    2'b10:   op = ALU_SLT;
                    2'b11:   op = ALU_SLTU;
                    default: op = ALU_SUB;
                endcase
            end
            default:    op = ALU_ADD;
        endcase
    end

    assign alu_control = ALU_OP_W'(op);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle instruction sequencer: fetch/decode/execute/mem/writeback with
// memory-wait timeout and a sticky trap state.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   S_FETCH     | instruction read in flight, ir_write on mem_ready
//   S_DECODE    | one cycle, opcode legality check and class capture
//   S_EXECUTE   | ALU active; branches resolve and retire here
//   S_MEM       | data read/write in flight for LOAD/STORE
//   S_WRITEBACK | register file and PC update, retire
//   S_TRAP      | illegal opcode or memory timeout, held until reset
module multicycle_controller
    import controller_pkg::*;
#(
    parameter int ALU_OP_W       = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    input  logic                mem_ready,
    input  logic                branch_taken,
    output logic [ALU_OP_W-1:0] alu_control,
    output logic                alu_src_imm,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_write,
    output logic                reg_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic [1:0]          wb_sel,
    output logic                trap,
    output logic                trap_cause,
    output logic [CNT_W-1:0]    instret
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [6:0]         op_q, op_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               trap_q, trap_d;
    logic               cause_q, cause_d;
    logic [CNT_W-1:0]   instret_q;
    logic               retire;

    logic [ALU_OP_W-1:0] dec_alu;
    logic                dec_imm;

    alu_decoder #(
        .ALU_OP_W (ALU_OP_W)
    ) u_alu_decoder (
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .alu_control (dec_alu),
        .alu_src_imm (dec_imm)
    );

    // State, captured opcode class, wait counter, trap flags and retire count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    // Next-state and output decode. The wait counter only advances while a
    // memory request is pending; any other cycle leaves it at zero, so both
    // FETCH and MEM start counting from zero on entry.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wait_d      = '0;
        trap_d      = trap_q;
        cause_d     = cause_q;
        retire      = 1'b0;
        alu_control = '0;
        alu_src_imm = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        wb_sel      = 2'd0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (is_legal_opcode(opcode)) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 1'b0;
                end
            end
            S_EXECUTE: begin
                alu_control = dec_alu;
                alu_src_imm = dec_imm;
                if (op_q == OPC_BRANCH) begin
                    pc_write = 1'b1;
                    pc_src   = branch_taken;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (op_q == OPC_LOAD || op_q == OPC_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OPC_STORE);
                if (mem_ready) begin
                    if (op_q == OPC_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                pc_src    = (op_q == OPC_JAL);
                if (op_q == OPC_LOAD) begin
                    wb_sel = 2'd1;
                end else if (op_q == OPC_JAL) begin
                    wb_sel = 2'd2;
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Hold every output quiet while reset is asserted.
        if (reset) begin
            alu_control = '0;
            alu_src_imm = 1'b0;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            pc_write    = 1'b0;
            pc_src      = 1'b0;
            wb_sel      = 2'd0;
            retire      = 1'b0;
        end
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: table of decode vectors plus
// hand-written multi-cycle sequences.
module tb_multicycle_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        mem_ready;
    logic        branch_taken;
    logic [3:0]  alu_control;
    logic        alu_src_imm;
    logic        mem_req;
    logic        mem_we;
    logic        ir_write;
    logic        reg_write;
    logic        pc_write;
    logic        pc_src;
    logic [1:0]  wb_sel;
    logic        trap;
    logic        trap_cause;
    logic [31:0] instret;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_controller #(
        .ALU_OP_W       (4),
        .TIMEOUT_CYCLES (4),
        .CNT_W          (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .alu_control  (alu_control),
        .alu_src_imm  (alu_src_imm),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_write     (ir_write),
        .reg_write    (reg_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .wb_sel       (wb_sel),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .instret      (instret)
    );

    always #5 clock = ~clock;

    // Strobe bundle: {mem_req, mem_we, ir_write, reg_write, pc_write, pc_src, wb_sel}
    localparam logic [7:0] ST_NONE      = 8'b0000_0000;
    localparam logic [7:0] ST_FETCH_W   = 8'b1000_0000;
    localparam logic [7:0] ST_FETCH_R   = 8'b1010_0000;
    localparam logic [7:0] ST_STORE_W   = 8'b1100_0000;
    localparam logic [7:0] ST_STORE_R   = 8'b1100_1000;
    localparam logic [7:0] ST_WB_ALU    = 8'b0001_1000;
    localparam logic [7:0] ST_WB_LOAD   = 8'b0001_1001;
    localparam logic [7:0] ST_WB_JAL    = 8'b0001_1110;
    localparam logic [7:0] ST_BR_TAKEN  = 8'b0000_1100;
    localparam logic [7:0] ST_BR_NOT    = 8'b0000_1000;

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic       f7;
        logic       bt;
        logic [3:0] alu;
        logic       imm;
        logic [7:0] exs;
    } vec_t;

    vec_t vecs[22];

    function automatic logic [7:0] strobes();
        return {mem_req, mem_we, ir_write, reg_write, pc_write, pc_src, wb_sel};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic mr, input logic bt);
        mem_ready    = mr;
        branch_taken = bt;
        #1;
    endtask

    task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
        opcode   = opc;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    // Leaves the bench at the start of the first FETCH cycle after reset.
    task automatic do_reset();
        reset        = 1'b1;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // FETCH with immediate mem_ready, then DECODE; ends at the start of EXECUTE.
    task automatic fetch_decode(input string tag);
        drive(1'b1, 1'b0);
        chk({tag, " fetch strobes"}, 32'(strobes()), 32'(ST_FETCH_R));
        tick();
        drive(1'b0, 1'b0);
        chk({tag, " decode strobes"}, 32'(strobes()), 32'(ST_NONE));
        chk({tag, " decode alu"}, 32'(alu_control), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          opcode      f3      f7    bt    alu    imm   exec strobes
        vecs[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4'd0,  1'b0, ST_NONE};
        vecs[1]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4'd1,  1'b0, ST_NONE};
        vecs[2]  = '{7'b0110011, 3'b001, 1'b1, 1'b0, 4'd2,  1'b0, ST_NONE};
        vecs[3]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 4'd3,  1'b0, ST_NONE};
        vecs[4]  = '{7'b0110011, 3'b011, 1'b0, 1'b0, 4'd4,  1'b0, ST_NONE};
        vecs[5]  = '{7'b0110011, 3'b100, 1'b0, 1'b0, 4'd5,  1'b0, ST_NONE};
        vecs[6]  = '{7'b0110011, 3'b101, 1'b0, 1'b0, 4'd6,  1'b0, ST_NONE};
        vecs[7]  = '{7'b0110011, 3'b101, 1'b1, 1'b0, 4'd7,  1'b0, ST_NONE};
        vecs[8]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 4'd8,  1'b0, ST_NONE};
        vecs[9]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 4'd9,  1'b0, ST_NONE};
        vecs[10] = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4'd0,  1'b1, ST_NONE};
        vecs[11] = '{7'b0010011, 3'b101, 1'b1, 1'b0, 4'd7,  1'b1, ST_NONE};
        vecs[12] = '{7'b0010011, 3'b101, 1'b0, 1'b0, 4'd6,  1'b1, ST_NONE};
        vecs[13] = '{7'b0010011, 3'b011, 1'b0, 1'b0, 4'd4,  1'b1, ST_NONE};
        vecs[14] = '{7'b0000011, 3'b010, 1'b0, 1'b0, 4'd0,  1'b1, ST_NONE};
        vecs[15] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4'd0,  1'b1, ST_NONE};
        vecs[16] = '{7'b0110111, 3'b000, 1'b0, 1'b0, 4'd10, 1'b1, ST_NONE};
        vecs[17] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4'd0,  1'b0, ST_NONE};
        vecs[18] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 4'd1,  1'b0, ST_BR_TAKEN};
        vecs[19] = '{7'b1100011, 3'b001, 1'b0, 1'b0, 4'd1,  1'b0, ST_BR_NOT};
        vecs[20] = '{7'b1100011, 3'b100, 1'b0, 1'b1, 4'd3,  1'b0, ST_BR_TAKEN};
        vecs[21] = '{7'b1100011, 3'b111, 1'b0, 1'b0, 4'd4,  1'b0, ST_BR_NOT};

        reset        = 1'b1;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b1);
        #2;
        chk("reset strobes", 32'(strobes()), 32'(ST_NONE));
        chk("reset alu", 32'(alu_control), 32'd0);
        chk("reset trap", 32'({trap, trap_cause}), 32'd0);
        chk("reset instret", instret, 32'd0);
        do_reset();
        drive(1'b0, 1'b0);
        chk("post-reset fetch", 32'(strobes()), 32'(ST_FETCH_W));

        // Decode table: ALU code, immediate select and execute-cycle strobes.
        for (int i = 0; i < 22; i++) begin
            do_reset();
            set_instr(vecs[i].opc, vecs[i].f3, vecs[i].f7);
            fetch_decode($sformatf("vec%0d", i));
            drive(1'b0, vecs[i].bt);
            chk($sformatf("vec%0d exec alu", i), 32'(alu_control), 32'(vecs[i].alu));
            chk($sformatf("vec%0d exec imm", i), 32'(alu_src_imm), 32'(vecs[i].imm));
            chk($sformatf("vec%0d exec strobes", i), 32'(strobes()), 32'(vecs[i].exs));
        end

        // OP SUB, immediate mem_ready: reg_write in cycle 4.
        do_reset();
        set_instr(7'b0110011, 3'b000, 1'b1);
        fetch_decode("sub");
        drive(1'b0, 1'b0);
        chk("sub exec alu", 32'(alu_control), 32'd1);
        tick();
        drive(1'b0, 1'b0);
        chk("sub wb strobes", 32'(strobes()), 32'(ST_WB_ALU));
        chk("sub wb alu", 32'(alu_control), 32'd0);
        tick();
        drive(1'b0, 1'b0);
        chk("sub back to fetch", 32'(strobes()), 32'(ST_FETCH_W));
        chk("sub instret", instret, 32'd1);

        // LOAD, mem_ready on the third MEM cycle: 7 cycles F,D,E,M,M,M,WB.
        set_instr(7'b0000011, 3'b010, 1'b0);
        fetch_decode("load");
        drive(1'b0, 1'b0);
        chk("load exec imm", 32'(alu_src_imm), 32'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(k == 2, 1'b0);
            chk($sformatf("load mem%0d strobes", k), 32'(strobes()), 32'(ST_FETCH_W));
            tick();
        end
        drive(1'b0, 1'b0);
        chk("load wb strobes", 32'(strobes()), 32'(ST_WB_LOAD));
        tick();
        drive(1'b0, 1'b0);
        chk("load back to fetch", 32'(strobes()), 32'(ST_FETCH_W));
        chk("load instret", instret, 32'd2);

        // BEQ taken: resolves in EXECUTE, no register write.
        set_instr(7'b1100011, 3'b000, 1'b0);
        fetch_decode("beq");
        drive(1'b0, 1'b1);
        chk("beq exec strobes", 32'(strobes()), 32'(ST_BR_TAKEN));
        tick();
        drive(1'b0, 1'b0);
        chk("beq next is fetch", 32'(strobes()), 32'(ST_FETCH_W));
        chk("beq instret", instret, 32'd3);

        // JAL: writeback selects PC+4, PC from target.
        set_instr(7'b1101111, 3'b000, 1'b0);
        fetch_decode("jal");
        drive(1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        chk("jal wb strobes", 32'(strobes()), 32'(ST_WB_JAL));
        tick();
        drive(1'b0, 1'b0);
        chk("jal instret", instret, 32'd4);

        // STORE: one wait cycle in MEM, retires on mem_ready.
        set_instr(7'b0100011, 3'b010, 1'b0);
        fetch_decode("store");
        drive(1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        chk("store mem wait", 32'(strobes()), 32'(ST_STORE_W));
        tick();
        drive(1'b1, 1'b0);
        chk("store mem ready", 32'(strobes()), 32'(ST_STORE_R));
        tick();
        drive(1'b0, 1'b0);
        chk("store back to fetch", 32'(strobes()), 32'(ST_FETCH_W));
        chk("store instret", instret, 32'd5);

        // mem_ready on the 4th FETCH cycle still wins, then an illegal opcode traps.
        set_instr(7'b1111111, 3'b000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0);
            chk($sformatf("edge fetch wait%0d", k), 32'(strobes()), 32'(ST_FETCH_W));
            tick();
        end
        drive(1'b1, 1'b0);
        chk("edge fetch ready", 32'(strobes()), 32'(ST_FETCH_R));
        tick();
        drive(1'b0, 1'b0);
        chk("edge decode reached", 32'(strobes()), 32'(ST_NONE));
        chk("edge decode no trap", 32'(trap), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1);
            chk($sformatf("illegal trap%0d flags", k), 32'({trap, trap_cause}), 32'b10);
            chk($sformatf("illegal trap%0d strobes", k), 32'(strobes()), 32'(ST_NONE));
            chk($sformatf("illegal trap%0d alu", k), 32'(alu_control), 32'd0);
            tick();
        end
        chk("illegal instret", instret, 32'd5);

        do_reset();
        drive(1'b0, 1'b0);
        chk("trap cleared", 32'({trap, trap_cause}), 32'd0);
        chk("instret cleared", instret, 32'd0);

        // FETCH timeout: 4 wait cycles then trap with cause 1.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0);
            chk($sformatf("fto wait%0d", k), 32'(strobes()), 32'(ST_FETCH_W));
            tick();
        end
        drive(1'b1, 1'b0);
        chk("fto flags", 32'({trap, trap_cause}), 32'b11);
        chk("fto strobes", 32'(strobes()), 32'(ST_NONE));

        // MEM timeout on a LOAD.
        do_reset();
        set_instr(7'b0000011, 3'b010, 1'b0);
        fetch_decode("mto");
        drive(1'b0, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0);
        chk("mto flags", 32'({trap, trap_cause}), 32'b11);
        chk("mto strobes", 32'(strobes()), 32'(ST_NONE));

        // Reset asserted while a STORE is waiting in MEM.
        do_reset();
        set_instr(7'b0100011, 3'b010, 1'b0);
        fetch_decode("rmem");
        drive(1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        chk("rmem in mem", 32'(strobes()), 32'(ST_STORE_W));
        reset = 1'b1;
        #1;
        chk("rmem during reset", 32'(strobes()), 32'(ST_NONE));
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0);
        chk("rmem fetch after", 32'(strobes()), 32'(ST_FETCH_W));
        chk("rmem instret", instret, 32'd0);
        drive(1'b1, 1'b0);
        chk("rmem fetch ready", 32'(strobes()), 32'(ST_FETCH_R));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter ALU_OP_W, default 4, ALU control width (minimum 4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of memory wait cycles before a trap.
REQ-003 SHALL have parameter CNT_W, default 32, retired-instruction counter width.
REQ-004 SHALL have port clock, input, 1, the single clock, rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port opcode, input, 7, instruction opcode field, valid from DECODE onward.
REQ-007 SHALL have port funct3, input, 3, instruction funct3 field.
REQ-008 SHALL have port funct7_5, input, 1, instruction bit 30.
REQ-009 SHALL have port mem_ready, input, 1, memory completes the current request this cycle.
REQ-010 SHALL have port branch_taken, input, 1, datapath compare result, sampled in EXECUTE.
REQ-011 SHALL have port alu_control, output, ALU_OP_W, ALU operation code.
REQ-012 SHALL have port alu_src_imm, output, 1, ALU operand B is the immediate.
REQ-013 SHALL have ports mem_req/mem_we, output, 1 each, memory request and write enable.
REQ-014 SHALL have ports ir_write/reg_write/pc_write, output, 1 each, single-cycle update strobes.
REQ-015 SHALL have port pc_src, output, 1, 0=PC+4, 1=branch/jump target.
REQ-016 SHALL have port wb_sel, output, 2, 0=ALU, 1=memory, 2=PC+4.
REQ-017 SHALL have port trap, output, 1, sticky illegal-opcode or timeout flag.
REQ-018 SHALL have port trap_cause, output, 1, 0=illegal opcode, 1=memory timeout.
REQ-019 SHALL have port instret, output, CNT_W, retired-instruction count.

Function
REQ-020 SHALL implement states FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
REQ-021 SHALL, in FETCH, assert mem_req with mem_we=0; on mem_ready, pulse ir_write and go to DECODE.
REQ-022 SHALL, in DECODE (1 cycle), go to EXECUTE for LUI 0110111, JAL 1101111, OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011 and BRANCH 1100011, and otherwise go to TRAP with trap_cause=0.
REQ-023 SHALL, in EXECUTE, drive alu_control as follows: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10; all values are zero-extended to ALU_OP_W.
REQ-024 SHALL decode OP as {funct7_5,funct3}; funct7_5 selects SUB for funct3=000 and SRA for funct3=101.
REQ-025 SHALL decode OP-IMM from funct3, applying funct7_5 for funct3=101 only.
REQ-026 SHALL use ADD for LOAD/STORE/JAL, PASS_B for LUI, and SUB/SLT/SLTU for BRANCH funct3 {000,001}/{100,101}/{110,111}.
REQ-027 SHALL assert alu_src_imm for OP-IMM, LOAD, STORE and LUI.
REQ-028 SHALL, for BRANCH in EXECUTE, pulse pc_write with pc_src=branch_taken, retire the instruction, and go to FETCH.
REQ-029 SHALL, for LOAD/STORE, go from EXECUTE to MEM; MEM asserts mem_req, with mem_we=1 for STORE.
REQ-030 SHALL, on mem_ready in MEM, go to WRITEBACK for a LOAD and to FETCH for a STORE, pulsing pc_write with pc_src=0 and retiring the STORE.
REQ-031 SHALL, for OP/OP-IMM/LUI/JAL, go from EXECUTE to WRITEBACK.
REQ-032 SHALL, in WRITEBACK, pulse reg_write and pc_write and set wb_sel (LOAD=1, JAL=2, else 0), with pc_src=1 only for JAL; it then retires the instruction and goes to FETCH.
REQ-033 SHALL count consecutive wait cycles in FETCH/MEM, reset the count on entering either state, and go to TRAP with trap_cause=1 when the count reaches TIMEOUT_CYCLES without mem_ready.
REQ-034 SHALL treat mem_ready on the same cycle the count reaches TIMEOUT_CYCLES as success.
REQ-035 SHALL keep TRAP absorbing until reset: all strobes 0, trap=1.
REQ-036 SHALL increment instret by 1 per retirement, wrapping modulo 2^CNT_W.
REQ-037 SHALL keep every strobe a single-cycle pulse, and SHALL drive alu_control to 0 outside EXECUTE.

Reset
REQ-038 SHALL, on reset, immediately enter FETCH and clear trap, trap_cause, instret and the wait counter; all outputs go to 0 and mem_req asserts in the first cycle after release.
REQ-039 SHALL abandon the in-flight instruction without retirement when reset asserts mid-instruction.

Structure
REQ-040 SHALL place the opcode enum, the ALU op constants and the state enum in the shared package controller_pkg.
REQ-041 SHALL implement decoding in a combinational sub-module alu_decoder (opcode, funct3, funct7_5 -> alu_control, alu_src_imm).

Verification
REQ-042 SHALL cover an OP SUB with immediate mem_ready: alu_control=1, reg_write in cycle 4, instret=1.
REQ-043 SHALL cover a LOAD with mem_ready delayed 3 cycles in MEM: wb_sel=1 in WRITEBACK, 7 cycles total.
REQ-044 SHALL cover BEQ with branch_taken=1: pc_write=1, pc_src=1 in EXECUTE, no reg_write.
REQ-045 SHALL cover opcode 1111111: trap=1, trap_cause=0, and no strobes afterwards until reset.
REQ-046 SHALL cover mem_ready held low in FETCH with TIMEOUT_CYCLES=4: trap_cause=1 after 4 cycles; mem_ready on the 4th cycle instead yields DECODE.
REQ-047 SHALL cover reset asserted in MEM: state is FETCH and instret is unchanged.
